// File: rtl/adder_issue_ctrl_if.sv
// adder_issue_ctrl_if: operand, adder and result ports of the adder issue controller
interface adder_issue_ctrl_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_en;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         chk_err;
  modport master (
    input  in_valid, in_a, in_b, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, add_en, res_valid, res_sum, res_cout, chk_err
  );
  modport slave (
    output in_valid, in_a, in_b, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_en, res_valid, res_sum, res_cout, chk_err
  );
endinterface

// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl: FIFO-buffered issue sequencer for the enable-latched carry adder.
// Define ADDER_ISSUE_CHECK_EN to add a sticky reference-adder check on each captured result.
module adder_issue_ctrl #(
  parameter int W      = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 5
) (
  input logic clk,
  input logic rst,
  adder_issue_ctrl_if.master io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d, res_sum_q, res_sum_d;
  logic          res_cout_q, res_cout_d, res_valid_q, res_valid_d;
  logic          empty, full, push, pop, capture;
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push    = io.in_valid && io.in_ready;
  assign pop     = !empty && (state_q == S_IDLE || (state_q == S_HOLD && io.res_ready));
  assign capture = state_q == S_SETTLE && cnt_q == '0;
  assign wr_d    = wr_q + (AW+1)'(push);
  assign rd_d    = rd_q + (AW+1)'(pop);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    case (state_q)
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = CW'(SETTLE - 1);
      end
      S_SETTLE: begin
        cnt_d       = capture ? cnt_q : cnt_q - CW'(1);
        state_d     = capture ? S_HOLD : S_SETTLE;
        res_valid_d = capture ? 1'b1 : res_valid_q;
        res_sum_d   = capture ? io.add_sum : res_sum_q;
        res_cout_d  = capture ? io.add_cout : res_cout_q;
      end
      S_HOLD: begin
        state_d     = io.res_ready ? S_IDLE : S_HOLD;
        res_valid_d = !io.res_ready;
      end
      default: ;
    endcase
    // a pop always launches a new issue, overriding IDLE/HOLD exits
    if (pop) begin
      state_d = S_LOAD;
      add_a_d = mem_a_q[rd_q[AW-1:0]];
      add_b_d = mem_b_q[rd_q[AW-1:0]];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_q[AW-1:0]] <= io.in_a;
      mem_b_q[wr_q[AW-1:0]] <= io.in_b;
    end
  end
  assign io.in_ready  = !full && !rst;
  assign io.add_a     = add_a_q;
  assign io.add_b     = add_b_q;
  assign io.add_en    = state_q == S_LOAD;
  assign io.res_valid = res_valid_q;
  assign io.res_sum   = res_sum_q;
  assign io.res_cout  = res_cout_q;
`ifdef ADDER_ISSUE_CHECK_EN
  logic         chk_q, chk_d;
  logic [W:0]   ref_sum;
  assign ref_sum = {1'b0, add_a_q} + {1'b0, add_b_q};
  assign chk_d   = chk_q || (capture && ref_sum != {io.add_cout, io.add_sum});
  always_ff @(posedge clk) begin
    chk_q <= rst ? 1'b0 : chk_d;
  end
  assign io.chk_err = chk_q;
`else
  assign io.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_issue_ctrl.sv
// tb_adder_issue_ctrl: randomized self-checking bench with a latching adder model and a result scoreboard
module tb_adder_issue_ctrl;
  localparam int W = 16;
  localparam logic CHK_EXP =
`ifdef ADDER_ISSUE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flip = 1'b0;
  logic [W:0] lat = '0;
  logic [W:0] expq[$];
  int checks = 0;
  int errors = 0;

  adder_issue_ctrl_if #(.W(W)) io();
  adder_issue_ctrl #(.W(W), .DEPTH(4), .SETTLE(5)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;
  // behaves like the enable-latched adder: result latched while add_en is high
  always @(posedge clk) if (io.add_en) lat <= {1'b0, io.add_a} + {1'b0, io.add_b};
  assign io.add_sum  = lat[W-1:0] ^ {{(W-1){1'b0}}, flip};
  assign io.add_cout = lat[W];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    io.in_valid = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    io.res_ready = 1'b0;
    repeat (3) cyc();
    checks++;
    if (io.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", io.in_ready); end
    checks++;
    if ({io.add_a, io.add_b, io.add_en, io.res_valid, io.res_sum, io.res_cout, io.chk_err} !== '0) begin
      errors++;
      $display("FAIL rst_outputs got a=%h b=%h en=%b rv=%b sum=%h cout=%b chk=%b exp all 0",
               io.add_a, io.add_b, io.add_en, io.res_valid, io.res_sum, io.res_cout, io.chk_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", io.in_ready); end
    cyc();
  endtask

  task automatic test_basic(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
    int en_cnt = 0, en_at = -1, rv_at = -1, rv_cnt = 0;
    logic [W:0] got = '0;
    io.res_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_a = a;
    io.in_b = b;
    checks++;
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", io.in_ready); end
    cyc();
    idle_in();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (io.add_en === 1'b1) begin en_cnt++; en_at = k; end
      if (io.res_valid === 1'b1) begin
        rv_cnt++;
        if (rv_at < 0) begin rv_at = k; got = {io.res_cout, io.res_sum}; end
      end
    end
    checks++;
    if (en_cnt != 1 || en_at != 1) begin errors++; $display("FAIL basic_add_en got cnt=%0d at=%0d exp cnt=1 at=1", en_cnt, en_at); end
    checks++;
    if (rv_at != 7 || rv_cnt != 1) begin errors++; $display("FAIL basic_latency got at=%0d cnt=%0d exp at=7 cnt=1", rv_at, rv_cnt); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL basic_result %h+%h got %h exp %h", a, b, got, e); end
    checks++;
    if (io.chk_err !== 1'b0) begin errors++; $display("FAIL basic_chk_err got %b exp 0", io.chk_err); end
  endtask

  task automatic test_stream();
    int rv[$];
    int viol = 0;
    logic [2*W-1:0] prev;
    logic [W-1:0] a, b;
    logic [W:0] e;
    io.res_ready = 1'b1;
    prev = {io.add_a, io.add_b};
    for (int s = 0; s < 40; s++) begin
      if (s < 3) begin
        a = W'($urandom); b = W'($urandom);
        io.in_valid = 1'b1; io.in_a = a; io.in_b = b;
        if (io.in_ready === 1'b1) expq.push_back({1'b0, a} + {1'b0, b});
      end else idle_in();
      if ({io.add_a, io.add_b} !== prev && io.add_en !== 1'b1) viol++;
      prev = {io.add_a, io.add_b};
      if (io.res_valid === 1'b1) begin
        rv.push_back(s);
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        checks++;
        if ({io.res_cout, io.res_sum} !== e) begin errors++; $display("FAIL stream_result got %h exp %h", {io.res_cout, io.res_sum}, e); end
      end
      cyc();
    end
    checks++;
    if (rv.size() != 3 || rv[1] - rv[0] != 7 || rv[2] - rv[1] != 7) begin
      errors++;
      $display("FAIL stream_spacing got %0d pulses first=%0d exp 3 pulses 7 apart", rv.size(), rv.size() > 0 ? rv[0] : -1);
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL stream_operand_stable got %0d changes exp 0", viol); end
  endtask

  task automatic test_full();
    logic [W-1:0] pa[6], pb[6];
    int n = 0, first = -1, got_n = 0;
    logic acc;
    logic [W:0] e;
    for (int i = 0; i < 6; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); end
    io.res_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      io.in_valid = n < 6;
      if (n < 6) begin io.in_a = pa[n]; io.in_b = pb[n]; end
      acc = io.in_valid && io.in_ready;
      if (acc) expq.push_back({1'b0, pa[n]} + {1'b0, pb[n]});
      cyc();
      if (acc) n++;
    end
    checks++;
    if (n != 5 || io.in_ready !== 1'b0) begin errors++; $display("FAIL full_capacity got accepts=%0d in_ready=%b exp 5 and 0", n, io.in_ready); end
    checks++;
    if (io.res_valid !== 1'b1) begin errors++; $display("FAIL full_res_held got %b exp 1", io.res_valid); end
    io.res_ready = 1'b1;
    for (int s = 0; s < 80 && got_n < 6; s++) begin
      io.in_valid = n < 6;
      if (n < 6) begin io.in_a = pa[n]; io.in_b = pb[n]; end
      if (first >= 0 && s == first + 1) begin
        checks++;
        if (io.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_reassert got %b exp 1", io.in_ready); end
      end
      if (io.res_valid === 1'b1) begin
        if (first < 0) begin
          first = s;
          checks++;
          if (io.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_before_pop got %b exp 0", io.in_ready); end
        end
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        got_n++;
        checks++;
        if ({io.res_cout, io.res_sum} !== e) begin errors++; $display("FAIL full_order got %h exp %h", {io.res_cout, io.res_sum}, e); end
      end
      acc = io.in_valid && io.in_ready;
      if (acc) expq.push_back({1'b0, pa[n]} + {1'b0, pb[n]});
      cyc();
      if (acc) n++;
    end
    checks++;
    if (got_n != 6 || expq.size() != 0) begin errors++; $display("FAIL full_drain got %0d results exp 6", got_n); end
    idle_in();
    cyc();
  endtask

  task automatic test_rst_mid();
    int bad = 0;
    io.res_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      io.in_valid = 1'b1; io.in_a = W'($urandom) | 16'h0100; io.in_b = W'($urandom);
      cyc();
    end
    idle_in();
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({io.add_a, io.add_b, io.add_en, io.res_valid, io.res_sum, io.res_cout, io.chk_err, io.in_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got a=%h b=%h en=%b rv=%b sum=%h cout=%b rdy=%b exp all 0",
               io.add_a, io.add_b, io.add_en, io.res_valid, io.res_sum, io.res_cout, io.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (io.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", io.in_ready); end
    expq.delete();
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (io.res_valid !== 1'b0 || io.add_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_no_results got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_chk();
    logic [W-1:0] a, b;
    logic [W:0] e, got = 'x;
    logic seen = 1'b0;
    a = W'($urandom); b = W'($urandom);
    e = {1'b0, a} + {1'b0, b};
    io.res_ready = 1'b1;
    flip = 1'b1;
    io.in_valid = 1'b1; io.in_a = a; io.in_b = b;
    cyc();
    idle_in();
    for (int k = 0; k < 20 && !seen; k++) begin
      if (io.res_valid === 1'b1) begin seen = 1'b1; got = {io.res_cout, io.res_sum}; end
      cyc();
    end
    flip = 1'b0;
    checks++;
    if (!seen || got !== (e ^ 17'h1)) begin errors++; $display("FAIL chk_copy got %h exp %h", got, e ^ 17'h1); end
    cyc();
    checks++;
    if (io.chk_err !== CHK_EXP) begin errors++; $display("FAIL chk_set got %b exp %b", io.chk_err, CHK_EXP); end
    io.in_valid = 1'b1; io.in_a = W'($urandom); io.in_b = W'($urandom);
    cyc();
    idle_in();
    repeat (12) cyc();
    checks++;
    if (io.chk_err !== CHK_EXP) begin errors++; $display("FAIL chk_sticky got %b exp %b", io.chk_err, CHK_EXP); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (io.chk_err !== 1'b0) begin errors++; $display("FAIL chk_clear got %b exp 0", io.chk_err); end
    cyc();
  endtask

  task automatic test_random();
    int sent = 0, got = 0;
    logic acc;
    logic [W:0] e;
    expq.delete();
    for (int c = 0; c < 3000 && got < 40; c++) begin
      io.in_valid = sent < 40 && $urandom_range(0, 3) != 0;
      io.in_a = W'($urandom);
      io.in_b = W'($urandom);
      io.res_ready = $urandom_range(0, 2) != 0;
      if (io.res_valid === 1'b1 && io.res_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        got++;
        checks++;
        if ({io.res_cout, io.res_sum} !== e) begin errors++; $display("FAIL rand_result got %h exp %h", {io.res_cout, io.res_sum}, e); end
      end
      acc = io.in_valid && io.in_ready;
      if (acc) begin expq.push_back({1'b0, io.in_a} + {1'b0, io.in_b}); sent++; end
      cyc();
    end
    checks++;
    if (got != 40) begin errors++; $display("FAIL rand_count got %0d exp 40", got); end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_basic(16'h0001, 16'h0001, 17'h00002);
    test_basic(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    test_basic(16'hF1EF, 16'hF1EF, 17'h1E3DE);
    test_stream();
    test_full();
    test_rst_mid();
    test_chk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
